// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out word collector.
package sipo_pkg;

  typedef enum logic {
    StEmpty,
    StFull
  } hold_state_e;

  // Width needed to count 0..width inclusive.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter with load-1 and sync clear; wrap flags the completing increment.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inc,
  input  logic                        clr,
  input  logic                        load1,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        wrap
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] Last = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap = inc && !clr && !load1 && (cnt_q == Last);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = CW'(1);
    end else if (clr || wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// Serial-in/parallel-out word collector with a one-word valid/ready holding register
// and sticky overrun on dropped words.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin_valid,
  input  logic                        sin_bit,
  input  logic                        frame_start,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        overrun,
  input  logic                        ovr_clear,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        busy
);

  if (WIDTH < 2) begin : g_width_check
    $fatal(1, "sipo_collector: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q;
  logic             overrun_q, overrun_d;
  logic             complete, load_dout, drop;
  hold_state_e      state_q, state_d;

  sipo_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (sin_valid & ~frame_start),
    .clr  (frame_start & ~sin_valid),
    .load1(frame_start & sin_valid),
    .cnt  (bit_cnt),
    .wrap (complete)
  );

  assign busy = (bit_cnt != '0);

  // A frame_start bit rebuilds the word from that bit alone.
  always_comb begin
    shreg_d = shreg_q;
    if (sin_valid && frame_start) begin
      shreg_d = MSB_FIRST ? {{(WIDTH - 1){1'b0}}, sin_bit} : {sin_bit, {(WIDTH - 1){1'b0}}};
    end else if (sin_valid) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], sin_bit} : {sin_bit, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (complete) state_d = StFull;
      StFull:  if (dout_ready && !complete) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    dout_valid = (state_q == StFull);
    load_dout  = complete && (!dout_valid || dout_ready);
    drop       = complete && dout_valid && !dout_ready;
  end

  // Set wins over clear when both happen in one cycle.
  assign overrun_d = drop ? 1'b1 : (ovr_clear ? 1'b0 : overrun_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      overrun_q <= overrun_d;
      if (load_dout) begin
        dout_q <= shreg_d;
      end
    end
  end

  assign dout    = dout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       frame_start = 1'b0;
  logic       dout_ready = 1'b0;
  logic       ovr_clear = 1'b0;

  logic [7:0] m_dout, l_dout;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_busy, l_busy;
  logic [3:0] m_cnt, l_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .frame_start(frame_start), .dout(m_dout), .dout_valid(m_valid),
    .dout_ready(dout_ready), .overrun(m_ovr), .ovr_clear(ovr_clear),
    .bit_cnt(m_cnt), .busy(m_busy)
  );

  sipo_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .frame_start(frame_start), .dout(l_dout), .dout_valid(l_valid),
    .dout_ready(dout_ready), .overrun(l_ovr), .ovr_clear(ovr_clear),
    .bit_cnt(l_cnt), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    sin_valid   = 1'b1;
    sin_bit     = b;
    frame_start = fs;
    tick();
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Sends w[7] first; for the MSB-first instance that reconstructs w.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  initial begin
    logic [7:0] seq;

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dout", 32'(m_dout), 32'h0);
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_ovr", 32'(m_ovr), 32'h0);
    check("rst_cnt", 32'(m_cnt), 32'h0);
    check("rst_busy", 32'(m_busy), 32'h0);

    // 1/2: bits 1,1,0,1,0,0,0,0 back-to-back; MSB-first D0, LSB-first 0B
    dout_ready = 1'b1;
    seq = 8'b1101_0000;
    for (int i = 7; i >= 0; i--) begin
      send_bit(seq[i], 1'b0);
      if (i == 1) check("t1_valid_before", 32'(m_valid), 32'h0);
    end
    check("t1_valid", 32'(m_valid), 32'h1);
    check("t1_dout_msb", 32'(m_dout), 32'hD0);
    check("t2_valid_lsb", 32'(l_valid), 32'h1);
    check("t2_dout_lsb", 32'(l_dout), 32'h0B);
    check("t1_cnt_wrap", 32'(m_cnt), 32'h0);
    tick();
    check("t1_valid_1cyc", 32'(m_valid), 32'h0);
    check("t1_ovr", 32'(m_ovr), 32'h0);

    // 3: gapped bits of A5, one every 3 cycles
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("t3_cnt_pre", 32'(m_cnt), 32'(i));
      send_bit(seq[7-i], 1'b0);
      if (i < 7) begin
        check("t3_cnt", 32'(m_cnt), 32'(i + 1));
        check("t3_busy", 32'(m_busy), 32'h1);
        check("t3_valid", 32'(m_valid), 32'h0);
        tick();
        tick();
      end
    end
    check("t3_dout", 32'(m_dout), 32'hA5);
    check("t3_valid_done", 32'(m_valid), 32'h1);
    check("t3_cnt_done", 32'(m_cnt), 32'h0);
    check("t3_busy_done", 32'(m_busy), 32'h0);
    tick();

    // 4: overrun with consumer stalled
    dout_ready = 1'b0;
    send_word(8'h11);
    check("t4_dout1", 32'(m_dout), 32'h11);
    check("t4_ovr1", 32'(m_ovr), 32'h0);
    send_word(8'h22);
    check("t4_dout_held", 32'(m_dout), 32'h11);
    check("t4_valid_held", 32'(m_valid), 32'h1);
    check("t4_ovr_set", 32'(m_ovr), 32'h1);
    tick();
    check("t4_ovr_sticky", 32'(m_ovr), 32'h1);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    check("t4_ovr_clr", 32'(m_ovr), 32'h0);
    dout_ready = 1'b1;
    tick();
    check("t4_valid_drain", 32'(m_valid), 32'h0);

    // 5: back-to-back, ready only on second completion edge
    dout_ready = 1'b0;
    send_word(8'h5A);
    check("t5_dout1", 32'(m_dout), 32'h5A);
    seq = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) dout_ready = 1'b1;
      send_bit(seq[i], 1'b0);
      if (i != 0) check("t5_hold", 32'({m_valid, m_dout}), 32'h15A);
    end
    check("t5_valid", 32'(m_valid), 32'h1);
    check("t5_dout2", 32'(m_dout), 32'hC3);
    check("t5_ovr", 32'(m_ovr), 32'h0);
    tick();
    check("t5_drain", 32'(m_valid), 32'h0);

    // 6: resync on frame_start, then mid-word reset
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("t6_cnt5", 32'(m_cnt), 32'h5);
    dout_ready = 1'b0;
    seq = 8'h96;
    send_bit(seq[7], 1'b1);
    check("t6_cnt_fs", 32'(m_cnt), 32'h1);
    for (int i = 6; i >= 0; i--) send_bit(seq[i], 1'b0);
    check("t6_dout", 32'(m_dout), 32'h96);
    check("t6_valid", 32'(m_valid), 32'h1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t6_fs_clr", 32'(m_cnt), 32'h0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    check("t6_busy", 32'(m_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_dout", 32'(m_dout), 32'h0);
    check("t6_rst_valid", 32'(m_valid), 32'h0);
    check("t6_rst_cnt", 32'(m_cnt), 32'h0);
    check("t6_rst_busy", 32'(m_busy), 32'h0);
    check("t6_rst_ovr", 32'(m_ovr), 32'h0);
    dout_ready = 1'b1;
    send_word(8'h3C);
    check("t6_clean", 32'({m_valid, m_dout}), 32'h13C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
